// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled start/data/stop detection, 8N1-style framing.
// Latency: rx_valid (DATA_BITS+1)*OS_RATE + OS_RATE/2 ticks after start detect, plus 2 clk sync delay.
// Backpressure: none; rx_data is overwritten by each new good frame, rx_valid/frame_err are 1-clk pulses.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Tick counter compare points: middle of start bit, then one full bit period
    localparam logic [TW-1:0] TICK_MID  = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OS_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state_q,     state_d;
    logic                   rx_meta_q,   rx_meta_d;
    logic                   rx_s_q,      rx_s_d;
    logic [TW-1:0]          tick_cnt_q,  tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q,     shreg_d;
    logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   frame_err_q, frame_err_d;

    // Next-state logic: counters only move on baud_tick; WAIT_HIGH exits on any clk once the line is high
    always_comb begin
        rx_meta_d   = rx_in;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (baud_tick && !rx_s_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // A line that is back high at mid start bit was only a glitch
                        state_d    = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // Shift right so the first bit on the line ends up in the LSB
                        shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            // Bad stop bit: keep the old word, wait out a break before re-arming
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; synchronizer resets to the idle-high level
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
